ap_ctrl_launcher: RTL and testbench
===================================

// Module: ap_ctrl_launcher
// PURPOSE
// - Synthesizable initiator for the HLS block-level handshake: drives ap_start/ap_continue into a kernel's
//   ap_start/ap_ready/ap_done/ap_continue port set and launches a programmed number of back-to-back runs.
// - Measures per-run latency and the total batch time, and flags protocol violations.
// - Sits between the testbench or host control logic and the top-level kernel.
// - It is the driving counterpart to the dataflow monitors, which only observe the same signals.
// PARAMETERS
// - RUN_W  16  width of run count and run counters
// - GAP_W   8  width of the inter-run idle gap
// - CYC_W  32  width of all cycle counters; counters saturate at all-ones
// PORTS
// - clock              in   1      single clock; all logic is clocked on the rising edge
// - reset              in   1      synchronous, active-high
// - cfg_go             in   1      1-cycle pulse: start a batch; ignored while stat_busy=1
// - cfg_num_runs       in   RUN_W  number of runs, sampled on an accepted cfg_go
// - cfg_gap            in   GAP_W  idle cycles between ap_done and the next ap_start, sampled on cfg_go
// - ap_start           out  1      to kernel
// - ap_continue        out  1      to kernel (see CONFIGURATION)
// - ap_ready           in   1      from kernel
// - ap_done            in   1      from kernel
// - stat_busy          out  1      high while a batch is active
// - stat_done          out  1      1-cycle pulse when the batch completes
// - stat_runs_done     out  RUN_W  number of runs completed in the current/last batch
// - stat_last_lat      out  CYC_W  latency of the most recent run
// - stat_max_lat       out  CYC_W  maximum latency within the batch
// - stat_total_cyc     out  CYC_W  cycles from the accepted cfg_go up to the final ap_done, inclusive
// - err_spurious       out  1      sticky: ap_done seen outside START/WAIT_DONE, or ap_ready outside START
// BEHAVIOUR
// - Reset: state=IDLE. Every output is 0, except ap_continue=1 when AP_CTRL_CHAIN_EN is undefined.
//   Reset mid-run: ap_start is 0 from the cycle after reset is sampled high. The kernel is not drained.
// - States: IDLE, START, WAIT_DONE, GAP.
// - IDLE: cfg_go && cfg_num_runs!=0 -> START.
//   - Sampled: cfg_num_runs, cfg_gap.
//   - Cleared: all stat_* counters and err_spurious.
//   - stat_busy=1 from the next cycle.
//   cfg_go && cfg_num_runs==0 -> stat_done pulses the next cycle; no ap_start; state stays IDLE.
// - START: ap_start=1 (registered; asserted the cycle state==START) and held until ap_ready is sampled high.
//   - ap_ready && !ap_done -> WAIT_DONE
//   - ap_ready && ap_done in the same cycle -> run completes this cycle (see completion)
// - WAIT_DONE: ap_start=0; on ap_done the run completes.
// - Latency counter:
//   - It is 1 in the first START cycle and increments every cycle.
//   - On completion: stat_last_lat = counter value in the ap_done cycle, and stat_max_lat = max(stat_max_lat, that value).
//   - Fastest possible run (ready and done in the first START cycle) gives latency=1.
// - Completion:
//   - stat_runs_done++ on every completion.
//   - Not the last run: cfg_gap==0 -> START next cycle; otherwise -> GAP.
//   - Last run: stat_done pulses the next cycle, stat_busy drops the same cycle, and state goes to IDLE.
// - GAP: ap_start=0. Counts cfg_gap cycles, then goes to START.
// - stat_total_cyc increments every cycle while stat_busy=1, and also in the final ap_done cycle.
// - Saturation: all CYC_W counters stop at 2^CYC_W-1 and never wrap.
// - err_spurious: set on ap_done in IDLE or GAP, or on ap_ready outside START.
//   Cleared only by reset or an accepted cfg_go. The FSM ignores the offending event.
// - cfg_go in the same cycle as the final ap_done is ignored, because stat_busy is still 1.
// CONFIGURATION
// - AP_CTRL_CHAIN_EN defined: ap_continue is combinational and equals ap_done && (state==START || state==WAIT_DONE).
//   A kernel using the ap_ctrl_chain protocol holds ap_done until ap_continue, so completion is unchanged.
//   ap_continue is 0 in all other cycles, including reset.
// - AP_CTRL_CHAIN_EN undefined: ap_continue is tied to 1'b1, which is ap_ctrl_hs behaviour.
// TESTING
// 1. Kernel model with fixed latency 10, ready in the first START cycle.
//    Stimulus: num_runs=3, gap=0.
//    Expect: 3 ap_start windows, stat_last_lat=stat_max_lat=10, stat_runs_done=3, one stat_done pulse, stat_total_cyc=30.
// 2. Kernel latencies 5, 12, 7; num_runs=3, gap=4.
//    Expect: stat_max_lat=12, stat_last_lat=7, exactly 4 idle cycles between each done and the next start.
// 3. Kernel delays ap_ready by 3 cycles after ap_start.
//    Expect: ap_start held for 4 cycles, and latency includes the wait.
//    Then ready and done in the same cycle -> latency=1 and no WAIT_DONE visit.
// 4. num_runs=0 -> stat_done pulses 1 cycle after cfg_go, ap_start never rises.
//    A second cfg_go during a batch is ignored, and the run count is unchanged.
// 5. Inject ap_done in IDLE -> err_spurious=1. Next cfg_go clears it.
//    Reset asserted mid-WAIT_DONE -> all outputs at reset values the next cycle.
// 6. With AP_CTRL_CHAIN_EN: kernel holds done until continue.
//    Expect: ap_continue high only in done cycles, and results match scenario 1.

Source files
------------

// File: rtl/ap_ctrl_launcher.sv
// ap_ctrl_launcher: initiator for the HLS block-level handshake. Launches a
// programmed batch of back-to-back kernel runs and records per-run latency,
// the peak latency, the total batch time and any protocol violations.
// Build option: define AP_CTRL_CHAIN_EN for ap_ctrl_chain (ap_continue
// pulses with ap_done); when it is undefined ap_continue is tied high
// (ap_ctrl_hs).
module ap_ctrl_launcher #(
   parameter int unsigned RUN_W = 16,
   parameter int unsigned GAP_W = 8,
   parameter int unsigned CYC_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_go,
   input  logic [RUN_W-1:0] cfg_num_runs,
   input  logic [GAP_W-1:0] cfg_gap,
   output logic             ap_start,
   output logic             ap_continue,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             stat_busy,
   output logic             stat_done,
   output logic [RUN_W-1:0] stat_runs_done,
   output logic [CYC_W-1:0] stat_last_lat,
   output logic [CYC_W-1:0] stat_max_lat,
   output logic [CYC_W-1:0] stat_total_cyc,
   output logic             err_spurious
);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

   state_t           state_q, state_d;
   state_t           after_run;
   logic [RUN_W-1:0] num_runs_q, num_runs_d;
   logic [RUN_W-1:0] runs_done_q, runs_done_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [CYC_W-1:0] lat_q, lat_d;
   logic [CYC_W-1:0] last_lat_q, last_lat_d;
   logic [CYC_W-1:0] max_lat_q, max_lat_d;
   logic [CYC_W-1:0] total_q, total_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             go_ok;
   logic             complete;
   logic             last_run;
   logic             spurious;
   logic             new_run;

   // Saturating increment shared by every cycle counter.
   function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] x);
      return (x == '1) ? x : x + CYC_W'(1);
   endfunction

   // Decode per-cycle handshake events from the current state.
   always_comb begin
      go_ok    = (state_q == IDLE) && cfg_go;
      complete = ((state_q == START) && ap_ready && ap_done) ||
                 ((state_q == WAIT_DONE) && ap_done);
      last_run = (runs_done_q == (num_runs_q - RUN_W'(1)));
      spurious = (ap_done && ((state_q == IDLE) || (state_q == GAP))) ||
                 (ap_ready && (state_q != START));
      if (last_run) begin
         after_run = IDLE;
      end else if (gap_q == '0) begin
         after_run = START;
      end else begin
         after_run = GAP;
      end
   end

   // Next-state logic of the run sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (cfg_go && (cfg_num_runs != '0)) state_d = START;
         START:     if (ap_ready) state_d = ap_done ? after_run : WAIT_DONE;
         WAIT_DONE: if (ap_done) state_d = after_run;
         GAP:       if (gap_cnt_q == GAP_W'(1)) state_d = START;
         default:   state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latency, statistics, gap and error bookkeeping.
   always_comb begin
      num_runs_d  = num_runs_q;
      gap_d       = gap_q;
      runs_done_d = runs_done_q;
      last_lat_d  = last_lat_q;
      max_lat_d   = max_lat_q;
      total_d     = total_q;
      gap_cnt_d   = gap_cnt_q;
      lat_d       = lat_q;
      err_d       = err_q;
      // A back-to-back START->START hop after a completion starts a fresh run.
      new_run     = (state_d == START) && ((state_q != START) || complete);

      if (go_ok) begin
         num_runs_d  = cfg_num_runs;
         gap_d       = cfg_gap;
         runs_done_d = '0;
         last_lat_d  = '0;
         max_lat_d   = '0;
         total_d     = '0;
         err_d       = 1'b0;
      end else if (state_q != IDLE) begin
         total_d = sat_inc(total_q);
      end

      if (new_run) begin
         lat_d = CYC_W'(1);
      end else if ((state_q == START) || (state_q == WAIT_DONE)) begin
         lat_d = sat_inc(lat_q);
      end

      if (complete) begin
         runs_done_d = runs_done_q + RUN_W'(1);
         last_lat_d  = lat_q;
         if (lat_q > max_lat_q) max_lat_d = lat_q;
         gap_cnt_d   = gap_q;
      end else if (state_q == GAP) begin
         gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end

      done_d = (complete && last_run) || (go_ok && (cfg_num_runs == '0));
      if (spurious) err_d = 1'b1;
   end

   // Datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         num_runs_q  <= '0;
         gap_q       <= '0;
         runs_done_q <= '0;
         last_lat_q  <= '0;
         max_lat_q   <= '0;
         total_q     <= '0;
         gap_cnt_q   <= '0;
         lat_q       <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         num_runs_q  <= num_runs_d;
         gap_q       <= gap_d;
         runs_done_q <= runs_done_d;
         last_lat_q  <= last_lat_d;
         max_lat_q   <= max_lat_d;
         total_q     <= total_d;
         gap_cnt_q   <= gap_cnt_d;
         lat_q       <= lat_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Kernel-facing and status outputs decoded from registered state.
   always_comb begin
      ap_start       = (state_q == START);
      stat_busy      = (state_q != IDLE);
      stat_done      = done_q;
      stat_runs_done = runs_done_q;
      stat_last_lat  = last_lat_q;
      stat_max_lat   = max_lat_q;
      stat_total_cyc = total_q;
      err_spurious   = err_q;
`ifdef AP_CTRL_CHAIN_EN
      ap_continue    = !reset && ap_done &&
                       ((state_q == START) || (state_q == WAIT_DONE));
`else
      ap_continue    = 1'b1;
`endif
   end

endmodule

// File: tb/tb_ap_ctrl_launcher.sv
// Self-checking bench for ap_ctrl_launcher: table-driven batches, corner
// sequences and randomized batches against a batch-level reference model.
module tb_ap_ctrl_launcher;

   localparam int RUN_W = 16;
   localparam int GAP_W = 8;
   localparam int CYC_W = 6;
   localparam int SAT   = (1 << CYC_W) - 1;
`ifdef AP_CTRL_CHAIN_EN
   localparam bit CHAIN = 1'b1;
`else
   localparam bit CHAIN = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             cfg_go = 1'b0;
   logic [RUN_W-1:0] cfg_num_runs = '0;
   logic [GAP_W-1:0] cfg_gap = '0;
   logic             ap_start;
   logic             ap_continue;
   logic             ap_ready = 1'b0;
   logic             ap_done = 1'b0;
   logic             stat_busy;
   logic             stat_done;
   logic [RUN_W-1:0] stat_runs_done;
   logic [CYC_W-1:0] stat_last_lat;
   logic [CYC_W-1:0] stat_max_lat;
   logic [CYC_W-1:0] stat_total_cyc;
   logic             err_spurious;

   ap_ctrl_launcher #(.RUN_W(RUN_W), .GAP_W(GAP_W), .CYC_W(CYC_W)) dut (
      .clock(clock), .reset(reset), .cfg_go(cfg_go), .cfg_num_runs(cfg_num_runs),
      .cfg_gap(cfg_gap), .ap_start(ap_start), .ap_continue(ap_continue),
      .ap_ready(ap_ready), .ap_done(ap_done), .stat_busy(stat_busy),
      .stat_done(stat_done), .stat_runs_done(stat_runs_done),
      .stat_last_lat(stat_last_lat), .stat_max_lat(stat_max_lat),
      .stat_total_cyc(stat_total_cyc), .err_spurious(err_spurious)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int lat_tab[4];

   typedef struct {
      string name;
      int    n, gap, rdly;
      int    l0, l1, l2, l3;
      int    e_last, e_max, e_total;
      bit    xgo;
   } vec_t;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle_outputs(input string nm);
      check({nm, "_start"}, ap_start, 0);
      check({nm, "_busy"}, stat_busy, 0);
      check({nm, "_done"}, stat_done, 0);
      check({nm, "_runs"}, stat_runs_done, 0);
      check({nm, "_last"}, stat_last_lat, 0);
      check({nm, "_max"}, stat_max_lat, 0);
      check({nm, "_total"}, stat_total_cyc, 0);
      check({nm, "_err"}, err_spurious, 0);
      check({nm, "_cont"}, ap_continue, CHAIN ? 0 : 1);
   endtask

   // One batch against a kernel model: ready after rdly extra START cycles,
   // done when the run has lasted lat_tab[r] cycles (first START cycle = 1).
   task automatic run_batch(input string nm, input int n, input int gap, input int rdly,
                            input int e_last, input int e_max, input int e_total,
                            input bit xgo);
      int  r = 0, c = 0, idle = 0, hi = 0, cyc = 0, fin = -1;
      int  starts = 0, cont_bad = 0, gap_bad = 0, hold_bad = 0;
      bit  kact = 0, after_done = 0, seen = 0;
      cfg_go = 1'b1; cfg_num_runs = RUN_W'(n); cfg_gap = GAP_W'(gap);
      step();
      cfg_go = 1'b0;
      check({nm, "_busy_after_go"}, stat_busy, 1);
      check({nm, "_err_clr_go"}, err_spurious, 0);
      while (cyc < 5000) begin
         if (stat_done) begin
            seen = 1;
            break;
         end
         if (ap_start && !kact) begin
            starts++;
            if (r < n) begin
               kact = 1; c = 1; hi = 0;
               if (after_done && idle != gap) gap_bad++;
            end
         end else if (kact) begin
            c++;
         end
         if (ap_start) hi++;
         if (!ap_start && after_done && stat_busy) idle++;
         ap_ready = kact && ap_start && (c == rdly + 1);
         ap_done  = kact && (c == lat_tab[r]);
         if (xgo) begin
            cfg_go = (cyc == 3);
            cfg_num_runs = RUN_W'(7);
         end
         #1;
         if (ap_continue != (CHAIN ? ap_done : 1'b1)) cont_bad++;
         if (ap_done) begin
            if (hi != rdly + 1) hold_bad++;
            kact = 0; r++; after_done = 1; idle = 0;
            if (r == n) fin = cyc;
         end
         @(posedge clock);
         #1;
         ap_ready = 1'b0; ap_done = 1'b0; cfg_go = 1'b0;
         cyc++;
      end
      check({nm, "_done_seen"}, seen, 1);
      check({nm, "_done_timing"}, cyc, fin + 1);
      check({nm, "_busy_at_done"}, stat_busy, 0);
      check({nm, "_runs"}, stat_runs_done, n);
      check({nm, "_starts"}, starts, n);
      check({nm, "_last"}, stat_last_lat, e_last);
      check({nm, "_max"}, stat_max_lat, e_max);
      check({nm, "_total"}, stat_total_cyc, e_total);
      check({nm, "_gap_cycles_bad"}, gap_bad, 0);
      check({nm, "_start_hold_bad"}, hold_bad, 0);
      check({nm, "_continue_bad"}, cont_bad, 0);
      check({nm, "_err"}, err_spurious, 0);
      step();
      check({nm, "_done_one_pulse"}, stat_done, 0);
      check({nm, "_no_restart"}, ap_start, 0);
   endtask

   initial begin
      vec_t vt[7];
      vt[0] = '{"s1_lat10",    3, 0, 0, 10, 10, 10, 0, 10, 10, 30, 0};
      vt[1] = '{"s2_var_gap4", 3, 4, 0,  5, 12,  7, 0,  7, 12, 32, 0};
      vt[2] = '{"s3_ready_dly",1, 0, 3,  8,  0,  0, 0,  8,  8,  8, 0};
      vt[3] = '{"s3_dly_gap1", 2, 1, 3,  4,  9,  0, 0,  9,  9, 14, 0};
      vt[4] = '{"s3_same_cyc", 2, 0, 0,  1,  1,  0, 0,  1,  1,  2, 0};
      vt[5] = '{"s4_extra_go", 2, 2, 0,  9,  6,  0, 0,  6,  9, 17, 1};
      vt[6] = '{"sat_lat70",   1, 0, 0, 70,  0,  0, 0, SAT, SAT, SAT, 0};

      repeat (3) @(posedge clock);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;
      step();
      check_idle_outputs("post_reset");

      for (int unsigned i = 0; i < 7; i++) begin
         lat_tab[0] = vt[i].l0; lat_tab[1] = vt[i].l1;
         lat_tab[2] = vt[i].l2; lat_tab[3] = vt[i].l3;
         run_batch(vt[i].name, vt[i].n, vt[i].gap, vt[i].rdly,
                   vt[i].e_last, vt[i].e_max, vt[i].e_total, vt[i].xgo);
      end

      // Zero-run batch: immediate done pulse, no kernel start.
      cfg_go = 1'b1; cfg_num_runs = '0; cfg_gap = '0;
      step();
      cfg_go = 1'b0;
      check("zero_done_pulse", stat_done, 1);
      check("zero_no_start", ap_start, 0);
      check("zero_not_busy", stat_busy, 0);
      step();
      check("zero_done_drop", stat_done, 0);
      check("zero_still_no_start", ap_start, 0);

      // Spurious done in IDLE sets the sticky error; the next batch clears it.
      ap_done = 1'b1;
      step();
      ap_done = 1'b0;
      check("spur_done_err", err_spurious, 1);
      check("spur_done_idle", stat_busy, 0);
      step();
      check("spur_sticky", err_spurious, 1);
      lat_tab[0] = 3;
      run_batch("after_spur", 1, 0, 0, 3, 3, 3, 0);
      ap_ready = 1'b1;
      step();
      ap_ready = 1'b0;
      check("spur_ready_err", err_spurious, 1);

      // Randomized batches against the batch-level model.
      for (int unsigned k = 0; k < 25; k++) begin
         int n, gap, rdly, sum, mx, tot;
         n = $urandom_range(1, 4);
         gap = $urandom_range(0, 5);
         rdly = $urandom_range(0, 3);
         sum = 0; mx = 0;
         for (int j = 0; j < 4; j++) begin
            lat_tab[j] = $urandom_range(rdly + 1, rdly + 15);
            if (j < n) begin
               sum += lat_tab[j];
               if (lat_tab[j] > mx) mx = lat_tab[j];
            end
         end
         tot = sum + gap * (n - 1);
         run_batch($sformatf("rnd%0d", k), n, gap, rdly,
                   (lat_tab[n-1] > SAT) ? SAT : lat_tab[n-1],
                   (mx > SAT) ? SAT : mx, (tot > SAT) ? SAT : tot, 0);
      end

      // Reset while waiting for done: everything back to reset values.
      cfg_go = 1'b1; cfg_num_runs = RUN_W'(2); cfg_gap = '0;
      step();
      cfg_go = 1'b0;
      ap_ready = 1'b1;
      step();
      ap_ready = 1'b0;
      step();
      step();
      check("mid_busy", stat_busy, 1);
      check("mid_wait_no_start", ap_start, 0);
      reset = 1'b1;
      step();
      check_idle_outputs("mid_reset");
      reset = 1'b0;
      step();
      check("mid_reset_stays_idle", ap_start, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
